shift_job_issuer: RTL
=====================

// Module: shift_job_issuer
// PURPOSE
//   Initiator side of the serial shifter start/done protocol. Queues shift requests from the
//   neuro interface and launches them one at a time on the shifter: drives operands and a
//   one-cycle start pulse, then waits for done. Returns each result in order on a
//   valid/ready response port, with timeout and illegal-mode protection.
// PARAMETERS
//   FIFO_DEPTH      4   request queue entries (power of 2, >=2)
//   TIMEOUT_CYCLES  40  max cycles in WAIT before abort (> 33 = worst-case shifter latency)
// PORTS
//   clk              in   1   single clock, rising edge
//   rst              in   1   asynchronous, active-high reset
//   req_valid        in   1   request present
//   req_ready        out  1   queue can accept (= !full)
//   req_data         in   32  operand
//   req_shamt        in   5   shift amount 0..31
//   req_mode         in   2   00 LSL, 01 LSR, 10 ASR, 11 illegal
//   rsp_valid        out  1   response present
//   rsp_ready        in   1   consumer accepts response
//   rsp_data         out  32  shifted result
//   rsp_error        out  1   1 = illegal mode or timeout
//   sh_start         out  1   start pulse to shifter
//   sh_data_in       out  32  operand to shifter
//   sh_shift_amount  out  5   shift amount to shifter
//   sh_mode          out  2   mode to shifter
//   sh_data_out      in   32  shifter result
//   sh_done          in   1   shifter done (level; stays high until next start)
//   busy             out  1   FSM not in IDLE
//   fifo_count       out  $clog2(FIFO_DEPTH)+1  queued entries
// BEHAVIOUR
//   Reset (async):
//   - All outputs 0 except req_ready=1.
//   - FSM to IDLE, FIFO emptied, timeout counter 0.
//   - Reset mid-operation aborts the job; no response is issued for it.
//   FIFO:
//   - Push on req_valid&&req_ready.
//   - Pop on the IDLE->LAUNCH/IDLE->RESP transition.
//   - Simultaneous push+pop when full is not possible (req_ready=0).
//   - Simultaneous push+pop otherwise leaves count unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - The in-flight job is not counted in fifo_count.
//   FSM states: IDLE, LAUNCH, WAIT, RESP.
//   - IDLE: if FIFO non-empty, pop the head into an operand register.
//       - mode!=11: go to LAUNCH.
//       - mode==11: go to RESP with rsp_error=1, rsp_data=operand; no start pulse.
//   - LAUNCH: exactly one cycle.
//       - sh_start=1 (registered output).
//       - sh_data_in/sh_shift_amount/sh_mode driven from the operand register.
//       - Operands held stable from LAUNCH until leaving WAIT.
//       - Go to WAIT; clear timeout counter.
//   - WAIT: sh_start=0. Register sh_done into done_q each cycle.
//       - Completion is the rising edge only (sh_done && !done_q); a stale high done is ignored.
//       - On completion: capture sh_data_out into rsp_data, rsp_error=0, go to RESP.
//       - Else counter++; at count==TIMEOUT_CYCLES: rsp_data=0, rsp_error=1, go to RESP.
//   - RESP: rsp_valid=1, rsp_data/rsp_error stable until rsp_valid&&rsp_ready.
//       - On handshake: rsp_valid drops next cycle, FSM to IDLE.
//   Ordering and timing:
//   - Responses are strictly in request order; one job in flight at a time.
//   - Empty-queue latency: req accepted at edge N -> LAUNCH at N+1 -> shifter result.
//   - Shifter result takes shamt+1 clocks after start -> rsp_valid one cycle after done rises.
//   - sh_start never high outside LAUNCH; never two pulses per job.
// TESTING
//   1 Assert rst async mid-cycle -> all outputs 0 immediately, req_ready=1, fifo_count=0.
//   2 Req 0x00000001, shamt 4, mode 00 -> single 1-cycle sh_start; rsp_data=0x00000010, rsp_error=0.
//   3 Req 0x80000000, shamt 31, mode 10 -> rsp_data=0xFFFFFFFF.
//     Then req 0x12345678, shamt 0, mode 01 -> rsp_data=0x12345678.
//   4 rsp_ready=0, push 6 reqs -> 5 accepted, then req_ready=0 with fifo_count=4.
//     Release rsp_ready -> 5 responses in order, values match each request.
//   5 Req mode 11, data 0xDEADBEEF -> no sh_start, rsp_error=1, rsp_data=0xDEADBEEF.
//     Shifter model holding done=0 -> rsp_error=1, rsp_data=0 after 40 WAIT cycles.
//   6 Assert rst during WAIT with 2 queued -> no response ever issued.
//     Post-reset new req completes normally.

Source files
------------

// File: rtl/shift_job_issuer.sv
// Initiator for the serial shifter start/done protocol: queues shift requests, launches one
// job at a time, and returns results in order with illegal-mode and timeout protection.
module shift_job_issuer #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [31:0]                   req_data,
  input  logic [4:0]                    req_shamt,
  input  logic [1:0]                    req_mode,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [31:0]                   rsp_data,
  output logic                          rsp_error,
  output logic                          sh_start,
  output logic [31:0]                   sh_data_in,
  output logic [4:0]                    sh_shift_amount,
  output logic [1:0]                    sh_mode,
  input  logic [31:0]                   sh_data_out,
  input  logic                          sh_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned WordW = 39;

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [WordW-1:0]  mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              done_q;
  logic [31:0]       op_data_q, op_data_d;
  logic [4:0]        op_shamt_q, op_shamt_d;
  logic [1:0]        op_mode_q, op_mode_d;
  logic              sh_start_q, sh_start_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_error_q, rsp_error_d;

  logic              full, empty, push, pop;
  logic [31:0]       head_data;
  logic [4:0]        head_shamt;
  logic [1:0]        head_mode;

  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = req_valid && !full;
  assign pop   = (state_q == StIdle) && !empty;
  assign {head_data, head_shamt, head_mode} = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    op_data_d   = op_data_q;
    op_shamt_d  = op_shamt_q;
    op_mode_d   = op_mode_q;
    sh_start_d  = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    tmo_d       = tmo_q;
    case (state_q)
      StIdle: begin
        if (!empty) begin
          op_data_d  = head_data;
          op_shamt_d = head_shamt;
          op_mode_d  = head_mode;
          if (head_mode == 2'b11) begin
            // Illegal mode never reaches the shifter; the operand is echoed back as the result.
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_data_d  = head_data;
            rsp_error_d = 1'b1;
          end else begin
            state_d    = StLaunch;
            sh_start_d = 1'b1;
          end
        end
      end
      StLaunch: begin
        state_d = StWait;
        tmo_d   = '0;
      end
      StWait: begin
        // Only a fresh rising edge counts; done left high by the previous job is stale.
        if (sh_done && !done_q) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_data_d  = sh_data_out;
          rsp_error_d = 1'b0;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
          if (tmo_d == TmoW'(TIMEOUT_CYCLES)) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_error_d = 1'b1;
          end
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tmo_q       <= '0;
      done_q      <= 1'b0;
      op_data_q   <= '0;
      op_shamt_q  <= '0;
      op_mode_q   <= '0;
      sh_start_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tmo_q       <= tmo_d;
      done_q      <= sh_done;
      op_data_q   <= op_data_d;
      op_shamt_q  <= op_shamt_d;
      op_mode_q   <= op_mode_d;
      sh_start_q  <= sh_start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_data, req_shamt, req_mode};
    end
  end

  assign req_ready       = !full;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_error       = rsp_error_q;
  assign sh_start        = sh_start_q;
  assign sh_data_in      = op_data_q;
  assign sh_shift_amount = op_shamt_q;
  assign sh_mode         = op_mode_q;
  assign busy            = (state_q != StIdle);
  assign fifo_count      = count_q;

endmodule
